// File: rtl/logic_unit_pipe.sv
// ============================================================================
// Module   : logic_unit_pipe
// Brief    : Registered 8-function bitwise logic unit with direct and
//            accumulate modes behind valid/ready handshakes.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module logic_unit_pipe #(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] ACC_INIT = '0,
    parameter int               COUNT_W  = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [2:0]         op_sel,
    input  logic               acc_mode,
    input  logic               acc_clear,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_zero,
    output logic               out_ones,
    output logic [WIDTH-1:0]   acc_value,
    output logic [COUNT_W-1:0] op_count
);

    localparam logic [COUNT_W-1:0] c_count_one = COUNT_W'(1);

    typedef enum logic [0:0] {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_data;
    logic               r_zero;
    logic               r_ones;
    logic [WIDTH-1:0]   r_acc;
    logic [COUNT_W-1:0] r_count;

    logic               w_accept;
    logic [WIDTH-1:0]   w_acc_eff;
    logic [WIDTH-1:0]   w_first;
    logic [WIDTH-1:0]   w_second;
    logic [WIDTH-1:0]   w_result;

    assign in_ready  = (r_state == ST_EMPTY) || out_ready;
    assign w_accept  = in_valid && in_ready;

    // A same-cycle clear feeds ACC_INIT into the accumulate operation.
    assign w_acc_eff = acc_clear ? ACC_INIT : r_acc;
    assign w_first   = acc_mode ? w_acc_eff : in_a;
    assign w_second  = acc_mode ? in_a      : in_b;

    always_comb begin
        w_result = '0;
        case (op_sel)
            3'd0:    w_result = w_first & w_second;
            3'd1:    w_result = ~(w_first & w_second);
            3'd2:    w_result = w_first | w_second;
            3'd3:    w_result = ~(w_first | w_second);
            3'd4:    w_result = w_first ^ w_second;
            3'd5:    w_result = ~(w_first ^ w_second);
            3'd6:    w_result = ~w_first;
            default: w_result = w_first;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_EMPTY: if (w_accept)               w_state_nxt = ST_FULL;
            ST_FULL:  if (out_ready && !w_accept) w_state_nxt = ST_EMPTY;
            default:                              w_state_nxt = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
            r_data  <= '0;
            r_zero  <= 1'b1;
            r_ones  <= 1'b0;
            r_acc   <= ACC_INIT;
            r_count <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_data  <= w_result;
                r_zero  <= (w_result == '0);
                r_ones  <= (w_result == '1);
                r_count <= r_count + c_count_one;
            end
            // A new accumulate result always wins over a clear.
            if (w_accept && acc_mode) begin
                r_acc <= w_result;
            end else if (acc_clear) begin
                r_acc <= ACC_INIT;
            end
        end
    end

    assign out_valid = (r_state == ST_FULL);
    assign out_data  = r_data;
    assign out_zero  = r_zero;
    assign out_ones  = r_ones;
    assign acc_value = r_acc;
    assign op_count  = r_count;

endmodule

`default_nettype wire

// File: tb/tb_logic_unit_pipe.sv
// ============================================================================
// Module   : tb_logic_unit_pipe
// Brief    : Scoreboard bench for logic_unit_pipe with a truth-table model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_logic_unit_pipe;

    localparam int               WIDTH    = 8;
    localparam logic [WIDTH-1:0] ACC_INIT = 8'hA5;
    localparam int               COUNT_W  = 4;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_a;
    logic [WIDTH-1:0]   in_b;
    logic [2:0]         op_sel;
    logic               acc_mode;
    logic               acc_clear;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   out_data;
    logic               out_zero;
    logic               out_ones;
    logic [WIDTH-1:0]   acc_value;
    logic [COUNT_W-1:0] op_count;

    logic_unit_pipe #(
        .WIDTH    (WIDTH),
        .ACC_INIT (ACC_INIT),
        .COUNT_W  (COUNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .op_sel    (op_sel),
        .acc_mode  (acc_mode),
        .acc_clear (acc_clear),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_zero  (out_zero),
        .out_ones  (out_ones),
        .acc_value (acc_value),
        .op_count  (op_count)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference state: pending results, accumulator, counter, buffer occupancy.
    logic [WIDTH-1:0]   exp_q[$];
    logic [WIDTH-1:0]   m_acc;
    logic [COUNT_W-1:0] m_count;
    logic               m_full;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Truth table per op, indexed by {first_bit, second_bit}.
    function automatic logic [3:0] truth(input logic [2:0] op);
        case (op)
            3'd0:    truth = 4'b1000;
            3'd1:    truth = 4'b0111;
            3'd2:    truth = 4'b1110;
            3'd3:    truth = 4'b0001;
            3'd4:    truth = 4'b0110;
            3'd5:    truth = 4'b1001;
            3'd6:    truth = 4'b0011;
            default: truth = 4'b1100;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] ref_op(input logic [2:0] op,
                                                input logic [WIDTH-1:0] f,
                                                input logic [WIDTH-1:0] s);
        logic [3:0] t;
        logic [WIDTH-1:0] r;
        t = truth(op);
        r = '0;
        for (int i = 0; i < WIDTH; i++) r[i] = t[{f[i], s[i]}];
        return r;
    endfunction

    task automatic model_reset();
        exp_q.delete();
        m_acc   = ACC_INIT;
        m_count = '0;
        m_full  = 1'b0;
    endtask

    // Model: predicts handshake and state, pushes expected results on accept.
    always @(negedge clk) begin
        if (rst_n) begin
            logic m_rdy;
            logic [WIDTH-1:0] eff, f, s, res;
            m_rdy = !m_full || out_ready;
            chk("in_ready", 32'(in_ready), 32'(m_rdy));
            chk("out_valid", 32'(out_valid), 32'(m_full));
            chk("acc_value", 32'(acc_value), 32'(m_acc));
            chk("op_count", 32'(op_count), 32'(m_count));
            eff = acc_clear ? ACC_INIT : m_acc;
            if (in_valid && m_rdy) begin
                f   = acc_mode ? eff  : in_a;
                s   = acc_mode ? in_a : in_b;
                res = ref_op(op_sel, f, s);
                exp_q.push_back(res);
                m_count = COUNT_W'((int'(m_count) + 1) % (1 << COUNT_W));
                if (acc_mode) m_acc = res;
                else if (acc_clear) m_acc = ACC_INIT;
                m_full = 1'b1;
            end else begin
                if (acc_clear) m_acc = ACC_INIT;
                if (out_ready) m_full = 1'b0;
            end
        end
    end

    // Monitor: compares the presented result with the oldest expected one.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                chk("out_valid_unexpected", 32'(out_valid), 32'(0));
            end else begin
                chk("out_data", 32'(out_data), 32'(exp_q[0]));
                chk("out_zero", 32'(out_zero), 32'(exp_q[0] == '0));
                chk("out_ones", 32'(out_ones), 32'(exp_q[0] == '1));
                if (out_ready) void'(exp_q.pop_front());
            end
        end
    end

    task automatic drive(input logic v, input logic [7:0] a, input logic [7:0] b,
                         input logic [2:0] op, input logic mode, input logic clr,
                         input logic ordy);
        @(posedge clk);
        #1;
        in_valid  = v;
        in_a      = a;
        in_b      = b;
        op_sel    = op;
        acc_mode  = mode;
        acc_clear = clr;
        out_ready = ordy;
    endtask

    task automatic idle(input logic ordy);
        drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b0, ordy);
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_a = '0; in_b = '0; op_sel = '0;
        acc_mode = 1'b0; acc_clear = 1'b0; out_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #2;
        chk("rst_out_valid", 32'(out_valid), 32'(0));
        chk("rst_out_data", 32'(out_data), 32'(0));
        chk("rst_out_zero", 32'(out_zero), 32'(1));
        chk("rst_out_ones", 32'(out_ones), 32'(0));
        chk("rst_acc", 32'(acc_value), 32'(ACC_INIT));
        chk("rst_count", 32'(op_count), 32'(0));
        rst_n = 1'b1;

        // Direct mode, all eight ops back-to-back.
        for (int op = 0; op < 8; op++)
            drive(1'b1, 8'hF0, 8'h3C, 3'(op), 1'b0, 1'b0, 1'b1);
        idle(1'b1);
        #1 chk("count_after_8", 32'(op_count), 32'(8));
        idle(1'b1);

        // Accumulate XOR from a freshly cleared accumulator.
        drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1, 1'b1);
        drive(1'b1, 8'h01, 8'h00, 3'd4, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 8'h02, 8'h00, 3'd4, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 8'h04, 8'h00, 3'd4, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 8'h80, 8'h00, 3'd4, 1'b1, 1'b0, 1'b1);
        idle(1'b1);
        #1 chk("acc_xor_chain", 32'(acc_value), 32'(ACC_INIT ^ 8'h87));

        // Backpressure: result held, new operands refused.
        drive(1'b1, 8'hAA, 8'h55, 3'd2, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 8'h11, 8'h22, 3'd0, 1'b0, 1'b0, 1'b0);
            #1;
            chk("stall_in_ready", 32'(in_ready), 32'(0));
            chk("stall_data", 32'(out_data), 32'(8'hFF));
            chk("stall_ones", 32'(out_ones), 32'(1));
        end
        drive(1'b0, 8'h11, 8'h22, 3'd0, 1'b0, 1'b0, 1'b1);
        #1 chk("ready_follows_out_ready", 32'(in_ready), 32'(1));
        idle(1'b1);

        // Clear wins as operand source but not over the new accumulate result.
        drive(1'b1, 8'h87, 8'h00, 3'd4, 1'b1, 1'b0, 1'b1);
        drive(1'b1, 8'hFF, 8'h00, 3'd0, 1'b1, 1'b1, 1'b1);
        idle(1'b1);
        #1 chk("clear_and_acc", 32'(acc_value), 32'(ACC_INIT));

        // Clear alone while stalled.
        drive(1'b1, 8'h0F, 8'h00, 3'd7, 1'b1, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 8'h00, 3'd0, 1'b0, 1'b1, 1'b0);
        idle(1'b0);
        #1 chk("clear_stalled", 32'(acc_value), 32'(ACC_INIT));
        idle(1'b1);

        // Randomised traffic; the 4-bit counter wraps many times.
        for (int i = 0; i < 600; i++)
            drive(($urandom % 4) != 0, 8'($urandom), 8'($urandom), 3'($urandom),
                  1'($urandom), ($urandom % 8) == 0, ($urandom % 3) != 0);

        // Asynchronous reset while a result is pending.
        drive(1'b1, 8'h3C, 8'hC3, 3'd4, 1'b0, 1'b0, 1'b0);
        idle(1'b0);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        chk("async_out_valid", 32'(out_valid), 32'(0));
        chk("async_acc", 32'(acc_value), 32'(ACC_INIT));
        chk("async_count", 32'(op_count), 32'(0));
        chk("async_zero", 32'(out_zero), 32'(1));
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int i = 0; i < 100; i++)
            drive(($urandom % 2) != 0, 8'($urandom), 8'($urandom), 3'($urandom),
                  1'($urandom), ($urandom % 8) == 0, ($urandom % 2) != 0);
        idle(1'b1);
        idle(1'b1);
        @(negedge clk);
        #1 chk("scoreboard_drained", 32'(exp_q.size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
